// File: rtl/sb_pkg.sv
// Shared types and constants for the destination-register scoreboard.
// A tag is {valid, rd}; invalid tags always carry rd=0.
package sb_pkg;

    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 2;
    localparam int TAG_W    = 6;
    localparam int REG_AW   = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
    } tag_t;

    // x0 and non-writing instructions never produce a trackable tag
    function automatic tag_t mk_tag(input logic valid, input logic wren,
                                    input logic [REG_AW-1:0] rd);
        tag_t t;
        t.valid = valid && wren && (rd != '0);
        t.rd    = t.valid ? rd : '0;
        return t;
    endfunction

endpackage

// File: rtl/sb_slot.sv
// One shadow tag register mirroring a pipeline register, with clear-over-enable
// priority and a flag for when its current tag leaves the pipeline.
module sb_slot
    import sb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_n,
    input  logic enable,
    input  logic next_copy,
    input  tag_t src_tag,
    output tag_t tag,
    output logic drop
);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag <= '0;
        end else if (!clear_n) begin
            tag <= '0;
        end else if (enable) begin
            tag <= src_tag;
        end
    end

    // The tag is lost if cleared, or replaced without the next stage taking it
    assign drop = tag.valid && (!clear_n || (enable && !next_copy));

endmodule

// File: rtl/rd_scoreboard.sv
// Pending-write scoreboard for the non-forwarding 5-stage RV32I pipeline:
// shadows rd of EX/MEM/WB, counts pending writes per register, flags RAW hazards in ID.
module rd_scoreboard
    import sb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_valid_i,
    input  logic                id_rd_wren_i,
    input  logic [REG_AW-1:0]   id_rd_addr_i,
    input  logic [REG_AW-1:0]   id_rs1_addr_i,
    input  logic [REG_AW-1:0]   id_rs2_addr_i,
    input  logic                id_is_rs2_i,
    input  logic                ex_enable_i,
    input  logic                mem_enable_i,
    input  logic                wb_enable_i,
    input  logic                ex_reset_ni,
    input  logic                mem_reset_ni,
    input  logic                wb_reset_ni,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                raw_stall_o,
    output logic [TAG_W-1:0]    ex_tag_o,
    output logic [TAG_W-1:0]    mem_tag_o,
    output logic [TAG_W-1:0]    wb_tag_o,
    output logic                err_o
);

    localparam int NET_W = CNT_W + 2;
    localparam logic signed [NET_W-1:0] NET_ONE = NET_W'(1);
    localparam logic signed [NET_W-1:0] NET_MAX = NET_W'((1 << CNT_W) - 1);

    tag_t id_tag;
    tag_t ex_tag;
    tag_t mem_tag;
    tag_t wb_tag;
    logic ex_drop;
    logic mem_drop;
    logic wb_drop;
    logic enter;

    logic [CNT_W-1:0]        count_q [NUM_REGS];
    logic [CNT_W-1:0]        count_d [NUM_REGS];
    logic                    err_q;
    logic                    err_d;
    logic signed [NET_W-1:0] net;
    logic [NUM_REGS-1:0]     busy;

    assign id_tag = mk_tag(id_valid_i, id_rd_wren_i, id_rd_addr_i);
    assign enter  = ex_reset_ni && ex_enable_i && id_tag.valid;

    sb_slot u_ex_slot (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear_n   (ex_reset_ni),
        .enable    (ex_enable_i),
        .next_copy (mem_reset_ni && mem_enable_i),
        .src_tag   (id_tag),
        .tag       (ex_tag),
        .drop      (ex_drop)
    );

    sb_slot u_mem_slot (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear_n   (mem_reset_ni),
        .enable    (mem_enable_i),
        .next_copy (wb_reset_ni && wb_enable_i),
        .src_tag   (ex_tag),
        .tag       (mem_tag),
        .drop      (mem_drop)
    );

    // Nothing follows WB, so any WB load or clear retires its tag
    sb_slot u_wb_slot (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear_n   (wb_reset_ni),
        .enable    (wb_enable_i),
        .next_copy (1'b0),
        .src_tag   (mem_tag),
        .tag       (wb_tag),
        .drop      (wb_drop)
    );

    // Sum one entry and up to three drops per register, saturating on error
    always_comb begin
        err_d = err_q;
        net   = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            net = $signed({2'b00, count_q[r]});
            if (enter && id_tag.rd == REG_AW'(r)) net = net + NET_ONE;
            if (ex_drop && ex_tag.rd == REG_AW'(r)) net = net - NET_ONE;
            if (mem_drop && mem_tag.rd == REG_AW'(r)) net = net - NET_ONE;
            if (wb_drop && wb_tag.rd == REG_AW'(r)) net = net - NET_ONE;
            if (net > NET_MAX) begin
                count_d[r] = '1;
                err_d      = 1'b1;
            end else if (net[NET_W-1]) begin
                count_d[r] = '0;
                err_d      = 1'b1;
            end else begin
                count_d[r] = net[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) count_q[r] <= count_d[r];
            err_q <= err_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) busy[r] = (count_q[r] != '0);
    end

    assign raw_stall_o = id_valid_i &&
                         (((id_rs1_addr_i != '0) && busy[id_rs1_addr_i]) ||
                          (id_is_rs2_i && (id_rs2_addr_i != '0) && busy[id_rs2_addr_i]));

    assign busy_o    = busy;
    assign ex_tag_o  = ex_tag;
    assign mem_tag_o = mem_tag;
    assign wb_tag_o  = wb_tag;
    assign err_o     = err_q;

endmodule

// File: tb/tb_rd_scoreboard.sv
// Self-checking bench for rd_scoreboard: directed scenarios plus constrained-random
// pipeline control compared against a slot-occupancy reference model.
module tb_rd_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_wren;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_is_rs2;
    logic        ex_en, mem_en, wb_en;
    logic        ex_rn, mem_rn, wb_rn;
    logic [31:0] busy;
    logic        raw_stall;
    logic [5:0]  ex_tag, mem_tag, wb_tag;
    logic        err;

    logic [5:0]  m_ex, m_mem, m_wb;
    int          n_checks;
    int          n_fail;

    rd_scoreboard dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rd_wren_i  (id_wren),
        .id_rd_addr_i  (id_rd),
        .id_rs1_addr_i (id_rs1),
        .id_rs2_addr_i (id_rs2),
        .id_is_rs2_i   (id_is_rs2),
        .ex_enable_i   (ex_en),
        .mem_enable_i  (mem_en),
        .wb_enable_i   (wb_en),
        .ex_reset_ni   (ex_rn),
        .mem_reset_ni  (mem_rn),
        .wb_reset_ni   (wb_rn),
        .busy_o        (busy),
        .raw_stall_o   (raw_stall),
        .ex_tag_o      (ex_tag),
        .mem_tag_o     (mem_tag),
        .wb_tag_o      (wb_tag),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tags held by each stage; a register is busy while any stage holds it
    function automatic logic [5:0] m_idtag();
        return (id_valid && id_wren && id_rd != 5'd0) ? {1'b1, id_rd} : 6'd0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) begin
            int n;
            n = 0;
            if (m_ex[5]  && m_ex[4:0]  == 5'(r)) n++;
            if (m_mem[5] && m_mem[4:0] == 5'(r)) n++;
            if (m_wb[5]  && m_wb[4:0]  == 5'(r)) n++;
            b[r] = (n > 0);
        end
        return b;
    endfunction

    function automatic logic m_stall();
        logic [31:0] b;
        b = m_busy();
        return id_valid && ((id_rs1 != 5'd0 && b[id_rs1]) ||
                            (id_is_rs2 && id_rs2 != 5'd0 && b[id_rs2]));
    endfunction

    task automatic step();
        logic [5:0] it, n_ex, n_mem, n_wb;
        @(posedge clk);
        it = m_idtag();
        if (rst) begin
            n_ex = '0; n_mem = '0; n_wb = '0;
        end else begin
            n_ex  = !ex_rn  ? 6'd0 : (ex_en  ? it    : m_ex);
            n_mem = !mem_rn ? 6'd0 : (mem_en ? m_ex  : m_mem);
            n_wb  = !wb_rn  ? 6'd0 : (wb_en  ? m_mem : m_wb);
        end
        m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
        #1;
    endtask

    task automatic set_id(input logic v, input logic w, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic is2);
        id_valid = v; id_wren = w; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_is_rs2 = is2;
    endtask

    task automatic set_ctl(input logic ee, input logic me, input logic we,
                           input logic er, input logic mr, input logic wr);
        ex_en = ee; mem_en = me; wb_en = we; ex_rn = er; mem_rn = mr; wb_rn = wr;
    endtask

    task automatic issue(input logic [4:0] rd);
        set_id(1'b1, 1'b1, rd, 5'd0, 5'd0, 1'b0);
        set_ctl(1, 1, 1, 1, 1, 1);
        step();
    endtask

    task automatic bubble();
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_ctl(1, 1, 1, 1, 1, 1);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bubble();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(1'b1, 1'b1, 5'd3, 5'd5, 5'd6, 1'b1);
        set_ctl(1, 1, 1, 1, 1, 1);
        step();
        rst = 1'b0;
        n_checks++;
        if ({ex_tag, mem_tag, wb_tag} !== 18'd0) begin
            n_fail++; $display("[TB] FAIL reset_tags: got %h required 0", {ex_tag, mem_tag, wb_tag});
        end
        n_checks++;
        if (busy !== 32'd0) begin
            n_fail++; $display("[TB] FAIL reset_busy: got %h required 0", busy);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_err: got %b required 0", err);
        end
        n_checks++;
        if (raw_stall !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_stall: got %b required 0", raw_stall);
        end
    endtask

    task automatic test_reset_mid_flight();
        issue(5'd5); issue(5'd6); issue(5'd7);
        n_checks++;
        if ({ex_tag, mem_tag, wb_tag} !== {6'h27, 6'h26, 6'h25}) begin
            n_fail++; $display("[TB] FAIL fill_tags: got %h required %h",
                               {ex_tag, mem_tag, wb_tag}, {6'h27, 6'h26, 6'h25});
        end
        n_checks++;
        if (busy !== 32'h0000_00E0) begin
            n_fail++; $display("[TB] FAIL fill_busy: got %h required 000000e0", busy);
        end
        rst = 1'b1;
        set_id(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        set_ctl(1, 1, 1, 0, 1, 0);
        step();
        rst = 1'b0;
        n_checks++;
        if ({ex_tag, mem_tag, wb_tag, busy, err} !== 51'd0) begin
            n_fail++; $display("[TB] FAIL midflight_reset: tags %h busy %h err %b required all 0",
                               {ex_tag, mem_tag, wb_tag}, busy, err);
        end
    endtask

    task automatic test_simple_raw();
        logic exp_stall [4];
        exp_stall = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        issue(5'd5);
        set_id(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
        set_ctl(1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (raw_stall !== exp_stall[i] || raw_stall !== m_stall()) begin
                n_fail++; $display("[TB] FAIL raw_stall[%0d]: got %b required %b", i, raw_stall, exp_stall[i]);
            end
            n_checks++;
            if (busy[5] !== exp_stall[i]) begin
                n_fail++; $display("[TB] FAIL raw_busy5[%0d]: got %b required %b", i, busy[5], exp_stall[i]);
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_flush();
        do_reset();
        issue(5'd8); issue(5'd9);
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_ctl(1, 0, 0, 0, 1, 1);
        step();
        n_checks++;
        if (ex_tag !== 6'd0 || mem_tag !== 6'h28) begin
            n_fail++; $display("[TB] FAIL flush_tags: ex %h mem %h required 00 28", ex_tag, mem_tag);
        end
        n_checks++;
        if (busy[9] !== 1'b0 || busy[8] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_busy: busy9 %b busy8 %b required 0 1", busy[9], busy[8]);
        end
        set_id(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        set_ctl(0, 0, 0, 1, 1, 1);
        step();
        n_checks++;
        if (ex_tag !== 6'd0 || mem_tag !== 6'h28 || busy !== 32'h0000_0100) begin
            n_fail++; $display("[TB] FAIL freeze: ex %h mem %h busy %h required 00 28 00000100",
                               ex_tag, mem_tag, busy);
        end
    endtask

    task automatic test_same_rd();
        logic exp_busy [3];
        exp_busy = '{1'b1, 1'b1, 1'b0};
        do_reset();
        issue(5'd12); issue(5'd12); issue(5'd12);
        n_checks++;
        if ({ex_tag, mem_tag, wb_tag} !== {3{6'h2C}} || busy[12] !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL same_rd_fill: tags %h busy12 %b err %b required 2c2c2c 1 0",
                               {ex_tag, mem_tag, wb_tag}, busy[12], err);
        end
        for (int i = 0; i < 3; i++) begin
            bubble();
            n_checks++;
            if (busy[12] !== exp_busy[i]) begin
                n_fail++; $display("[TB] FAIL same_rd_drain[%0d]: got %b required %b", i, busy[12], exp_busy[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic exp_busy [3];
        exp_busy = '{1'b1, 1'b1, 1'b0};
        do_reset();
        issue(5'd4); bubble(); issue(5'd4);
        n_checks++;
        if ({ex_tag, mem_tag, wb_tag} !== {6'h24, 6'h00, 6'h24}) begin
            n_fail++; $display("[TB] FAIL simul_setup: got %h required 240024", {ex_tag, mem_tag, wb_tag});
        end
        // EX tag displaced unclaimed, WB retires, a new rd=4 enters: net -1
        set_id(1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0);
        set_ctl(1, 0, 1, 1, 1, 1);
        step();
        n_checks++;
        if ({ex_tag, mem_tag, wb_tag} !== {6'h24, 6'h00, 6'h00} || busy[4] !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL simul_event: tags %h busy4 %b err %b required 240000 1 0",
                               {ex_tag, mem_tag, wb_tag}, busy[4], err);
        end
        for (int i = 0; i < 3; i++) begin
            bubble();
            n_checks++;
            if (busy[4] !== exp_busy[i]) begin
                n_fail++; $display("[TB] FAIL simul_drain[%0d]: got %b required %b", i, busy[4], exp_busy[i]);
            end
        end
        do_reset();
        issue(5'd7); bubble(); issue(5'd7);
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_ctl(1, 0, 1, 0, 1, 1);
        step();
        n_checks++;
        if (busy[7] !== 1'b0 || err !== 1'b0 || ex_tag !== 6'd0 || wb_tag !== 6'd0) begin
            n_fail++; $display("[TB] FAIL flush_retire: busy7 %b err %b ex %h wb %h required 0 0 00 00",
                               busy[7], err, ex_tag, wb_tag);
        end
    endtask

    task automatic test_x0();
        do_reset();
        issue(5'd0);
        set_id(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0);
        step();
        n_checks++;
        if (ex_tag !== 6'd0 || mem_tag !== 6'd0 || busy !== 32'd0) begin
            n_fail++; $display("[TB] FAIL x0_tags: ex %h mem %h busy %h required 0", ex_tag, mem_tag, busy);
        end
        set_id(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        n_checks++;
        if (raw_stall !== 1'b0) begin
            n_fail++; $display("[TB] FAIL x0_stall: got %b required 0", raw_stall);
        end
        issue(5'd10);
        set_id(1'b1, 1'b0, 5'd0, 5'd0, 5'd10, 1'b0);
        #1;
        n_checks++;
        if (raw_stall !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rs2_unused: got %b required 0", raw_stall);
        end
        id_is_rs2 = 1'b1;
        #1;
        n_checks++;
        if (raw_stall !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rs2_hit: got %b required 1", raw_stall);
        end
        id_valid = 1'b0;
        #1;
        n_checks++;
        if (raw_stall !== 1'b0) begin
            n_fail++; $display("[TB] FAIL id_bubble_stall: got %b required 0", raw_stall);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(5'd5);
        // EX holds while later stages keep copying it: retirements outnumber entries
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_ctl(0, 1, 1, 1, 1, 1);
        step(); step();
        n_checks++;
        if (busy[5] !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL dup_hold: busy5 %b err %b required 1 0", busy[5], err);
        end
        step();
        n_checks++;
        if (busy[5] !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL dup_retire: busy5 %b err %b required 0 0", busy[5], err);
        end
        step();
        n_checks++;
        if (busy[5] !== 1'b0 || err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL underflow: busy5 %b err %b required 0 1", busy[5], err);
        end
        set_ctl(0, 0, 0, 1, 1, 1);
        step();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("[TB] FAIL err_sticky: got %b required 1", err);
        end
        do_reset();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL err_clear: got %b required 0", err);
        end
    endtask

    task automatic test_random();
        logic ex_loads, mem_loads;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0);
            // Only realistic pipelines: a stage is copied only when its source also advances
            ex_rn     = ($urandom_range(0, 7) != 0);
            ex_en     = ($urandom_range(0, 3) != 0);
            ex_loads  = ex_rn && ex_en;
            mem_rn    = ($urandom_range(0, 7) != 0);
            mem_en    = ex_loads && ($urandom_range(0, 3) != 0);
            mem_loads = mem_rn && mem_en;
            wb_rn     = ($urandom_range(0, 7) != 0);
            wb_en     = mem_loads && ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (raw_stall !== m_stall()) begin
                n_fail++; $display("[TB] FAIL rand_stall[%0d]: got %b required %b", i, raw_stall, m_stall());
            end
            step();
            n_checks++;
            if ({ex_tag, mem_tag, wb_tag} !== {m_ex, m_mem, m_wb}) begin
                n_fail++; $display("[TB] FAIL rand_tags[%0d]: got %h required %h", i,
                                   {ex_tag, mem_tag, wb_tag}, {m_ex, m_mem, m_wb});
            end
            n_checks++;
            if (busy !== m_busy() || err !== 1'b0) begin
                n_fail++; $display("[TB] FAIL rand_busy[%0d]: busy %h err %b required %h 0", i,
                                   busy, err, m_busy());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        rst = 1'b1;
        set_id(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_ctl(1, 1, 1, 1, 1, 1);
        test_reset();
        test_reset_mid_flight();
        test_simple_raw();
        test_flush();
        test_same_rd();
        test_simultaneous();
        test_x0();
        test_underflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
